// File: rtl/boot_rom_mp_if.sv
// rtl/boot_rom_mp_if.sv - TCDM multi-port bus bundle between masters and the boot ROM
interface boot_rom_mp_if #(
    parameter int unsigned NB_PORTS = 2
);
    logic [NB_PORTS-1:0]    req_i;
    logic [NB_PORTS*32-1:0] add_i;
    logic [NB_PORTS-1:0]    wen_i;
    logic [NB_PORTS-1:0]    gnt_o;
    logic [NB_PORTS-1:0]    r_valid_o;
    logic [NB_PORTS*32-1:0] r_rdata_o;
    logic [NB_PORTS-1:0]    r_opc_o;

    modport master (
        output req_i, add_i, wen_i,
        input  gnt_o, r_valid_o, r_rdata_o, r_opc_o
    );

    modport slave (
        input  req_i, add_i, wen_i,
        output gnt_o, r_valid_o, r_rdata_o, r_opc_o
    );
endinterface

// File: rtl/boot_rom_mp.sv
// rtl/boot_rom_mp.sv - round-robin multi-port boot ROM; optional word parity under BOOT_ROM_PARITY_EN
module generic_rom #(
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  en_i,
    input  logic                  test_mode_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    output logic [DATA_WIDTH-1:0] q_o
);
    logic unused_test_mode;
    assign unused_test_mode = test_mode_i;

    // Image word: {parity, 16'hB007, index}; the last word carries inverted parity as a self-test sentinel
    function automatic logic [32:0] image_word(input logic [ADDR_WIDTH-1:0] a);
        logic [31:0] d;
        d = {16'hB007, 16'(a)};
        return {(^d) ^ (&a), d};
    endfunction

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            q_o <= DATA_WIDTH'(image_word(addr_i));
        end
    end
endmodule

module boot_rom_mp #(
    parameter int unsigned NB_PORTS       = 2,
    parameter int unsigned ROM_ADDR_WIDTH = 13,
    parameter logic [31:0] BASE_ADDR      = 32'h1A00_0000,
    parameter bit          OUT_REG        = 1'b0
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          init_ni,
    input  logic          test_mode_i,
    boot_rom_mp_if.slave  bus,
    output logic          err_o
);
    localparam int unsigned PW = (NB_PORTS > 1) ? $clog2(NB_PORTS) : 1;
`ifdef BOOT_ROM_PARITY_EN
    localparam int unsigned DW = 33;
`else
    localparam int unsigned DW = 32;
`endif
    localparam logic [32:0] ROM_SPAN = 33'd1 << ROM_ADDR_WIDTH;
    localparam logic [31:0] ERR_DATA = 32'hBADA_CCE5;

    logic [PW-1:0]       rr_q, gnt_idx;
    logic                gnt_any;
    int                  rr_k;
    logic [31:0]         add_sel, off;
    logic                in_range, rom_en;
    logic [DW-1:0]       rom_q;
    logic                s1_valid_q, s1_bad_q;
    logic [PW-1:0]       s1_port_q;
    logic [31:0]         resp_data;
    logic                resp_opc;
    logic                o_valid, o_opc;
    logic [PW-1:0]       o_port;
    logic [31:0]         o_data;
    logic                err_q;

    // Scan downwards so the lowest offset from the pointer wins
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        rr_k    = 0;
        for (int i = NB_PORTS - 1; i >= 0; i--) begin
            rr_k = int'(rr_q) + i;
            if (rr_k >= int'(NB_PORTS)) rr_k = rr_k - int'(NB_PORTS);
            if (init_ni && bus.req_i[PW'(rr_k)]) begin
                gnt_any = 1'b1;
                gnt_idx = PW'(rr_k);
            end
        end
    end

    assign bus.gnt_o = gnt_any ? (NB_PORTS'(1) << gnt_idx) : '0;

    assign add_sel  = bus.add_i[32*gnt_idx +: 32];
    assign off      = add_sel - BASE_ADDR;
    assign in_range = (add_sel >= BASE_ADDR) && ({1'b0, off} < ROM_SPAN);
    assign rom_en   = gnt_any && bus.wen_i[gnt_idx] && in_range;

    generic_rom #(
        .ADDR_WIDTH (ROM_ADDR_WIDTH - 2),
        .DATA_WIDTH (DW)
    ) u_rom (
        .clk_i       (clk_i),
        .en_i        (rom_en),
        .test_mode_i (test_mode_i),
        .addr_i      (off[ROM_ADDR_WIDTH-1:2]),
        .q_o         (rom_q)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q       <= '0;
            s1_valid_q <= 1'b0;
            s1_bad_q   <= 1'b0;
            s1_port_q  <= '0;
        end else begin
            s1_valid_q <= gnt_any;
            s1_bad_q   <= gnt_any && !rom_en;
            s1_port_q  <= gnt_idx;
            if (gnt_any) begin
                rr_q <= (gnt_idx == PW'(NB_PORTS - 1)) ? '0 : gnt_idx + 1'b1;
            end
        end
    end

    assign resp_data = s1_bad_q ? ERR_DATA : rom_q[31:0];
`ifdef BOOT_ROM_PARITY_EN
    assign resp_opc  = s1_bad_q | (^rom_q);
`else
    assign resp_opc  = s1_bad_q;
`endif

    generate
        if (OUT_REG) begin : g_out_reg
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    o_valid <= 1'b0;
                    o_port  <= '0;
                    o_data  <= '0;
                    o_opc   <= 1'b0;
                end else begin
                    o_valid <= s1_valid_q;
                    o_port  <= s1_port_q;
                    o_data  <= resp_data;
                    o_opc   <= resp_opc;
                end
            end
        end else begin : g_out_comb
            assign o_valid = s1_valid_q;
            assign o_port  = s1_port_q;
            assign o_data  = resp_data;
            assign o_opc   = resp_opc;
        end
    endgenerate

    // Idle ports see all-zero data and flags
    always_comb begin
        bus.r_valid_o = '0;
        bus.r_rdata_o = '0;
        bus.r_opc_o   = '0;
        for (int p = 0; p < NB_PORTS; p++) begin
            if (o_valid && (o_port == PW'(p))) begin
                bus.r_valid_o[p]        = 1'b1;
                bus.r_rdata_o[32*p +: 32] = o_data;
                bus.r_opc_o[p]          = o_opc;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else if (o_valid && o_opc) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
endmodule

// File: tb/tb_boot_rom_mp.sv
// tb/tb_boot_rom_mp.sv - directed self-checking bench for boot_rom_mp (OUT_REG 0 and 1)
module tb_boot_rom_mp;
    localparam logic [31:0] BASE = 32'h1A00_0000;

    logic clk = 1'b0;
    logic rst_n, init_n, test_mode;
    logic err0, err1;
    logic exp_par;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    boot_rom_mp_if #(.NB_PORTS(2)) bus0 ();
    boot_rom_mp_if #(.NB_PORTS(2)) bus1 ();

    boot_rom_mp #(.NB_PORTS(2), .ROM_ADDR_WIDTH(13), .BASE_ADDR(BASE), .OUT_REG(1'b0)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n), .init_ni(init_n), .test_mode_i(test_mode),
        .bus(bus0.slave), .err_o(err0)
    );

    boot_rom_mp #(.NB_PORTS(2), .ROM_ADDR_WIDTH(13), .BASE_ADDR(BASE), .OUT_REG(1'b1)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .init_ni(init_n), .test_mode_i(test_mode),
        .bus(bus1.slave), .err_o(err1)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef BOOT_ROM_PARITY_EN
        exp_par = 1'b1;
`else
        exp_par = 1'b0;
`endif
        rst_n = 1'b0; init_n = 1'b1; test_mode = 1'b0;
        bus0.req_i = '0; bus0.add_i = '0; bus0.wen_i = '1;
        bus1.req_i = '0; bus1.add_i = '0; bus1.wen_i = '1;
        step(); step();
        check("rst_valid", bus0.r_valid_o, 0);
        check("rst_rdata", bus0.r_rdata_o, 0);
        check("rst_opc",   bus0.r_opc_o, 0);
        check("rst_err",   err0, 0);
        rst_n = 1'b1;
        step();

        // two ports competing from reset: grants 0,1,0,1
        bus0.req_i = 2'b11; bus0.add_i = {BASE + 32'h24, BASE + 32'h10}; bus0.wen_i = 2'b11;
        #1;
        check("rr_c1_gnt", bus0.gnt_o, 2'b01);
        check("rr_c1_vld", bus0.r_valid_o, 2'b00);
        step(); #1;
        check("rr_c2_gnt", bus0.gnt_o, 2'b10);
        check("rr_c2_vld", bus0.r_valid_o, 2'b01);
        check("rr_c2_dat", bus0.r_rdata_o, {32'h0, 32'hB007_0004});
        check("rr_c2_opc", bus0.r_opc_o, 2'b00);
        step(); #1;
        check("rr_c3_gnt", bus0.gnt_o, 2'b01);
        check("rr_c3_vld", bus0.r_valid_o, 2'b10);
        check("rr_c3_dat", bus0.r_rdata_o, {32'hB007_0009, 32'h0});
        step(); #1;
        check("rr_c4_gnt", bus0.gnt_o, 2'b10);
        check("rr_c4_vld", bus0.r_valid_o, 2'b01);
        check("rr_c4_dat", bus0.r_rdata_o, {32'h0, 32'hB007_0004});
        step(); bus0.req_i = 2'b00; #1;
        check("rr_c5_gnt", bus0.gnt_o, 2'b00);
        check("rr_c5_vld", bus0.r_valid_o, 2'b10);
        check("rr_c5_dat", bus0.r_rdata_o, {32'hB007_0009, 32'h0});
        step(); #1;
        check("rr_c6_vld", bus0.r_valid_o, 2'b00);
        check("rr_c6_dat", bus0.r_rdata_o, 0);

        // out-of-range read then write on port 1
        bus0.req_i = 2'b10; bus0.add_i = {BASE + 32'h2000, 32'h0}; bus0.wen_i = 2'b11;
        #1;
        check("oor_gnt", bus0.gnt_o, 2'b10);
        check("oor_romen", u_dut0.rom_en, 0);
        step(); bus0.add_i = {BASE, 32'h0}; bus0.wen_i = 2'b01; #1;
        check("wr_gnt", bus0.gnt_o, 2'b10);
        check("wr_romen", u_dut0.rom_en, 0);
        check("oor_vld", bus0.r_valid_o, 2'b10);
        check("oor_dat", bus0.r_rdata_o, {32'hBADA_CCE5, 32'h0});
        check("oor_opc", bus0.r_opc_o, 2'b10);
        check("oor_err_pre", err0, 0);
        step(); bus0.req_i = 2'b00; bus0.wen_i = 2'b11; #1;
        check("wr_vld", bus0.r_valid_o, 2'b10);
        check("wr_dat", bus0.r_rdata_o, {32'hBADA_CCE5, 32'h0});
        check("wr_opc", bus0.r_opc_o, 2'b10);
        check("oor_err", err0, 1);
        step(); #1;
        check("err_idle_opc", bus0.r_opc_o, 2'b00);
        check("err_sticky", err0, 1);

        // byte offset bits are ignored
        bus0.req_i = 2'b01; bus0.add_i = {32'h0, BASE + 32'h13}; #1;
        check("boff_gnt", bus0.gnt_o, 2'b01);
        check("boff_romen", u_dut0.rom_en, 1);
        step(); bus0.req_i = 2'b00; #1;
        check("boff_dat", bus0.r_rdata_o, {32'h0, 32'hB007_0004});
        check("boff_opc", bus0.r_opc_o, 2'b00);

        // init low blocks grants but lets the issued one complete
        bus0.req_i = 2'b01; bus0.add_i = {32'h0, BASE + 32'h8}; #1;
        check("init_gnt", bus0.gnt_o, 2'b01);
        step(); init_n = 1'b0; #1;
        check("init_blk", bus0.gnt_o, 2'b00);
        check("init_vld", bus0.r_valid_o, 2'b01);
        check("init_dat", bus0.r_rdata_o, {32'h0, 32'hB007_0002});
        step(); #1;
        check("init_idle", bus0.r_valid_o, 2'b00);
        init_n = 1'b1; bus0.req_i = 2'b00;

        // reset right after an erroneous grant discards it and rewinds the pointer
        step(); bus0.req_i = 2'b01; bus0.add_i = {32'h0, BASE}; bus0.wen_i = 2'b10; #1;
        check("rst_pre_gnt", bus0.gnt_o, 2'b01);
        step(); rst_n = 1'b0; bus0.req_i = 2'b00; bus0.wen_i = 2'b11; #1;
        check("rst_mid_vld", bus0.r_valid_o, 2'b00);
        step(); rst_n = 1'b1;
        step(); #1;
        check("rst_post_vld", bus0.r_valid_o, 2'b00);
        check("rst_post_err", err0, 0);
        bus0.req_i = 2'b11; bus0.add_i = {BASE + 32'h4, BASE + 32'hC}; #1;
        check("rst_post_gnt", bus0.gnt_o, 2'b01);
        step(); bus0.req_i = 2'b00; #1;
        check("rst_post_dat", bus0.r_rdata_o, {32'h0, 32'hB007_0003});
        check("rst_post_err2", err0, 0);

        // OUT_REG=1: three back-to-back reads, two-cycle latency
        step(); bus1.req_i = 2'b01; bus1.add_i = {32'h0, BASE + 32'h4}; #1;
        check("or_g1", bus1.gnt_o, 2'b01);
        step(); bus1.add_i = {32'h0, BASE + 32'h8}; #1;
        check("or_g2", bus1.gnt_o, 2'b01);
        check("or_v_early", bus1.r_valid_o, 2'b00);
        step(); bus1.add_i = {32'h0, BASE + 32'hC}; #1;
        check("or_g3", bus1.gnt_o, 2'b01);
        check("or_v1", bus1.r_valid_o, 2'b01);
        check("or_d1", bus1.r_rdata_o, {32'h0, 32'hB007_0001});
        check("or_o1", bus1.r_opc_o, 2'b00);
        step(); bus1.req_i = 2'b00; #1;
        check("or_v2", bus1.r_valid_o, 2'b01);
        check("or_d2", bus1.r_rdata_o, {32'h0, 32'hB007_0002});
        step(); #1;
        check("or_v3", bus1.r_valid_o, 2'b01);
        check("or_d3", bus1.r_rdata_o, {32'h0, 32'hB007_0003});
        step(); #1;
        check("or_v_end", bus1.r_valid_o, 2'b00);

        // sentinel word with inverted stored parity
        bus1.req_i = 2'b10; bus1.add_i = {BASE + 32'h1FFC, 32'h0}; #1;
        check("par_gnt", bus1.gnt_o, 2'b10);
        step(); bus1.req_i = 2'b00; #1;
        check("par_v_early", bus1.r_valid_o, 2'b00);
        step(); #1;
        check("par_vld", bus1.r_valid_o, 2'b10);
        check("par_dat", bus1.r_rdata_o, {32'hB007_07FF, 32'h0});
        check("par_opc", bus1.r_opc_o, {exp_par, 1'b0});
        check("par_err_pre", err1, 0);
        step(); #1;
        check("par_err", err1, exp_par);
        check("par_idle", bus1.r_valid_o, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
